// File: rtl/wheel_emu_pkg.sv
// rtl/wheel_emu_pkg.sv - shared state type, direction codes and phase-counter width
package wheel_emu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GAP   = 3'd1,
    ST_LEAD  = 3'd2,
    ST_BOTH  = 3'd3,
    ST_TRAIL = 3'd4
  } state_e;

  localparam logic DIR_A2B = 1'b0;
  localparam logic DIR_B2A = 1'b1;

  localparam int PHASE_W = 8;

endpackage

// File: rtl/wheel_phase_timer.sv
// rtl/wheel_phase_timer.sv - loadable down-counter timing one sensor phase
module wheel_phase_timer
  import wheel_emu_pkg::*;
#(
  parameter int PHASE_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic run,
  output logic expire
);

  localparam logic [PHASE_W-1:0] RELOAD = PHASE_W'(PHASE_CYCLES - 1);
  localparam logic [PHASE_W-1:0] ONE    = PHASE_W'(1);

  logic [PHASE_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = RELOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = run && (cnt_q == '0);

endmodule

// File: rtl/wheel_sensor_emulator.sv
// rtl/wheel_sensor_emulator.sv - two-sensor axle waveform generator for one track
// Optional one-deep request queue enabled by WHEEL_EMU_QUEUE_EN.
module wheel_sensor_emulator
  import wheel_emu_pkg::*;
#(
  parameter int PHASE_CYCLES = 1,
  parameter int COUNT_W      = 4
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             start,
  input  logic             dir,
  input  logic [COUNT_W:0] wheel_count,
  input  logic             abort,
  output logic             a,
  output logic             b,
  output logic             busy,
  output logic             done,
  output logic [COUNT_W:0] wheels_sent
);

  localparam logic [COUNT_W:0] SENT_ONE = (COUNT_W + 1)'(1);

  state_e           state_q, state_d;
  logic             dir_q, dir_d;
  logic [COUNT_W:0] count_q, count_d;
  logic [COUNT_W:0] sent_q, sent_d, sent_inc;
  logic             a_q, a_d, b_q, b_d, done_q, done_d;
  logic             req, expire, load;
  logic             q_valid, q_dir;
  logic [COUNT_W:0] q_count;

  assign req      = start && (wheel_count != '0);
  assign sent_inc = sent_q + SENT_ONE;
  assign busy     = (state_q != ST_IDLE);

  wheel_phase_timer #(.PHASE_CYCLES(PHASE_CYCLES)) u_timer (
    .clk   (Clk),
    .rst_n (Reset_n),
    .load  (load),
    .run   (busy),
    .expire(expire)
  );

`ifdef WHEEL_EMU_QUEUE_EN
  logic             qv_q, qv_d, qdir_q, qdir_d, q_take;
  logic [COUNT_W:0] qcnt_q, qcnt_d;

  // Queue drains either from IDLE or on the final TRAIL edge of the running train.
  assign q_take = qv_q && !abort &&
                  ((state_q == ST_IDLE) ||
                   ((state_q == ST_TRAIL) && expire && (sent_inc == count_q)));

  always_comb begin
    qv_d   = qv_q;
    qdir_d = qdir_q;
    qcnt_d = qcnt_q;
    if (abort || q_take) begin
      qv_d = 1'b0;
    end else if (busy && req && !qv_q) begin
      qv_d   = 1'b1;
      qdir_d = dir;
      qcnt_d = wheel_count;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      qv_q   <= 1'b0;
      qdir_q <= DIR_A2B;
      qcnt_q <= '0;
    end else begin
      qv_q   <= qv_d;
      qdir_q <= qdir_d;
      qcnt_q <= qcnt_d;
    end
  end

  assign q_valid = qv_q;
  assign q_dir   = qdir_q;
  assign q_count = qcnt_q;
`else
  assign q_valid = 1'b0;
  assign q_dir   = DIR_A2B;
  assign q_count = '0;
`endif

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    count_d = count_q;
    sent_d  = sent_q;
    done_d  = 1'b0;
    load    = 1'b0;
    a_d     = 1'b0;
    b_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (q_valid) begin
          state_d = ST_GAP;
          dir_d   = q_dir;
          count_d = q_count;
          sent_d  = '0;
          load    = 1'b1;
        end else if (req) begin
          state_d = ST_GAP;
          dir_d   = dir;
          count_d = wheel_count;
          sent_d  = '0;
          load    = 1'b1;
        end
      end
      ST_GAP:  if (expire) begin state_d = ST_LEAD;  load = 1'b1; end
      ST_LEAD: if (expire) begin state_d = ST_BOTH;  load = 1'b1; end
      ST_BOTH: if (expire) begin state_d = ST_TRAIL; load = 1'b1; end
      ST_TRAIL: begin
        if (expire) begin
          load    = 1'b1;
          sent_d  = sent_inc;
          state_d = ST_GAP;
          if (sent_inc == count_q) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
            if (q_valid) begin
              state_d = ST_GAP;
              dir_d   = q_dir;
              count_d = q_count;
              sent_d  = '0;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort) begin
      state_d = ST_IDLE;
      dir_d   = dir_q;
      count_d = count_q;
      sent_d  = sent_q;
      done_d  = 1'b0;
    end

    // Sensor levels follow the next state so a/b come straight from flops.
    case (state_d)
      ST_LEAD:  begin a_d = (dir_d == DIR_A2B); b_d = (dir_d == DIR_B2A); end
      ST_BOTH:  begin a_d = 1'b1;               b_d = 1'b1;               end
      ST_TRAIL: begin a_d = (dir_d == DIR_B2A); b_d = (dir_d == DIR_A2B); end
      default:  begin a_d = 1'b0;               b_d = 1'b0;               end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_A2B;
      count_q <= '0;
      sent_q  <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      count_q <= count_d;
      sent_q  <= sent_d;
      a_q     <= a_d;
      b_q     <= b_d;
      done_q  <= done_d;
    end
  end

  assign a           = a_q;
  assign b           = b_q;
  assign done        = done_q;
  assign wheels_sent = sent_q;

endmodule

// File: tb/tb_wheel_sensor_emulator.sv
// tb/tb_wheel_sensor_emulator.sv - self-checking bench, two emulators (P=1 and P=2) on shared inputs
module tb_wheel_sensor_emulator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, dir, abort;
  logic [4:0] wheel_count;
  logic       a0, b0, busy0, done0, a1, b1, busy1, done1;
  logic [4:0] ws0, ws1;
  logic [8:0] obs [2];
  logic [8:0] exp_o [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wheel_sensor_emulator #(.PHASE_CYCLES(1), .COUNT_W(4)) u_dut_p1 (
    .Clk(clk), .Reset_n(rst_n), .start(start), .dir(dir), .wheel_count(wheel_count),
    .abort(abort), .a(a0), .b(b0), .busy(busy0), .done(done0), .wheels_sent(ws0)
  );

  wheel_sensor_emulator #(.PHASE_CYCLES(2), .COUNT_W(4)) u_dut_p2 (
    .Clk(clk), .Reset_n(rst_n), .start(start), .dir(dir), .wheel_count(wheel_count),
    .abort(abort), .a(a1), .b(b1), .busy(busy1), .done(done1), .wheels_sent(ws1)
  );

  assign obs[0] = {a0, b0, busy0, done0, ws0};
  assign obs[1] = {a1, b1, busy1, done1, ws1};

  // Reference: each train is described by its start edge k, direction and wheel count;
  // outputs at edge c follow from t = c - k with plain division.
`ifdef WHEEL_EMU_QUEUE_EN
  localparam bit QEN = 1'b1;
`else
  localparam bit QEN = 1'b0;
`endif

  int   cyc = 0;
  bit   m_act [2];
  int   m_k [2], m_n [2], m_hold [2], m_qn [2];
  logic m_dir [2], m_qd [2];
  bit   m_done [2], m_qv [2];

  function automatic int pof(int d);
    return (d == 0) ? 1 : 2;
  endfunction

  function automatic logic [1:0] ab_of(int ph, logic d);
    case (ph)
      1:       return d ? 2'b01 : 2'b10;
      2:       return 2'b11;
      3:       return d ? 2'b10 : 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit was, req, qvb;
    int p, t;
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        m_act[d] = 0; m_done[d] = 0; m_qv[d] = 0; m_hold[d] = 0;
        m_k[d] = 0; m_n[d] = 0; m_dir[d] = 0; m_qd[d] = 0; m_qn[d] = 0;
        exp_o[d] = '0;
      end
    end else begin
      cyc++;
      for (int d = 0; d < 2; d++) begin
        was = m_act[d];
        qvb = m_qv[d];
        p   = pof(d);
        req = start && (wheel_count != 0);
        m_done[d] = 0;
        if (abort) begin
          if (was) begin
            m_hold[d] = (cyc - 1 - m_k[d]) / (4 * p);
            m_act[d]  = 0;
          end
          m_qv[d] = 0;
        end else begin
          if (was && cyc == m_k[d] + 4 * m_n[d] * p) begin
            m_done[d] = 1;
            m_hold[d] = m_n[d];
            m_act[d]  = 0;
            if (qvb) begin
              m_act[d] = 1; m_k[d] = cyc; m_dir[d] = m_qd[d]; m_n[d] = m_qn[d]; m_qv[d] = 0;
            end
          end else if (!was) begin
            if (qvb) begin
              m_act[d] = 1; m_k[d] = cyc; m_dir[d] = m_qd[d]; m_n[d] = m_qn[d]; m_qv[d] = 0;
            end else if (req) begin
              m_act[d] = 1; m_k[d] = cyc; m_dir[d] = dir; m_n[d] = int'(wheel_count);
            end
          end
          if (QEN && was && req && !qvb) begin
            m_qv[d] = 1; m_qd[d] = dir; m_qn[d] = int'(wheel_count);
          end
        end
        if (m_act[d]) begin
          t = cyc - m_k[d];
          exp_o[d] = {ab_of((t / p) % 4, m_dir[d]), 1'b1, m_done[d], 5'(t / (4 * p))};
        end else begin
          exp_o[d] = {2'b00, 1'b0, m_done[d], 5'(m_hold[d])};
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; dir = 1'b0; abort = 1'b0; wheel_count = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (obs[d] !== 9'd0) begin
        n_fail++;
        $display("FAIL reset_hold dut%0d got=%b want=%b", d, obs[d], 9'd0);
      end
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (obs[d] !== 9'd0) begin
        n_fail++;
        $display("FAIL reset_release dut%0d got=%b want=%b", d, obs[d], 9'd0);
      end
    end
  endtask

  task automatic test_forward();
    for (int t = 0; t < 140; t++) begin
      start = (t == 0); dir = 1'b0; wheel_count = 5'd16;
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if (obs[d] !== exp_o[d]) begin
          n_fail++;
          $display("FAIL forward dut%0d t=%0d got=%b want=%b", d, t, obs[d], exp_o[d]);
        end
      end
      if (t == 64) begin
        n_checks++;
        if (done0 !== 1'b1 || busy0 !== 1'b0 || ws0 !== 5'd16) begin
          n_fail++;
          $display("FAIL forward_end done=%b busy=%b ws=%0d want 1 0 16", done0, busy0, ws0);
        end
      end
    end
  endtask

  task automatic test_reverse();
    for (int t = 0; t < 30; t++) begin
      start = (t == 0); dir = 1'b1; wheel_count = 5'd3;
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if (obs[d] !== exp_o[d]) begin
          n_fail++;
          $display("FAIL reverse dut%0d t=%0d got=%b want=%b", d, t, obs[d], exp_o[d]);
        end
      end
      if (t == 24) begin
        n_checks++;
        if (done1 !== 1'b1 || ws1 !== 5'd3) begin
          n_fail++;
          $display("FAIL reverse_end_p2 done=%b ws=%0d want 1 3", done1, ws1);
        end
      end
    end
  endtask

  task automatic test_abort();
    for (int t = 0; t < 20; t++) begin
      start = (t == 0); dir = 1'b0; wheel_count = 5'd8; abort = (t == 10);
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if (obs[d] !== exp_o[d]) begin
          n_fail++;
          $display("FAIL abort dut%0d t=%0d got=%b want=%b", d, t, obs[d], exp_o[d]);
        end
      end
      if (t == 10) begin
        n_checks++;
        if ({a0, b0, busy0, done0, ws0} !== {4'b0000, 5'd2}) begin
          n_fail++;
          $display("FAIL abort_state got=%b want=%b", {a0, b0, busy0, done0, ws0}, {4'b0000, 5'd2});
        end
      end
    end
    abort = 1'b0;
  endtask

  task automatic test_ignored();
    for (int t = 0; t < 4; t++) begin
      start = 1'b1; dir = 1'b0; wheel_count = 5'd0;
      @(posedge clk); #1;
      n_checks++;
      if (busy0 !== 1'b0 || busy1 !== 1'b0) begin
        n_fail++;
        $display("FAIL zero_count busy=%b%b want=00", busy0, busy1);
      end
    end
    for (int t = 0; t < 60; t++) begin
      start = (t == 0) || (t == 5); dir = (t == 5); wheel_count = (t == 0) ? 5'd4 : 5'd2;
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if (obs[d] !== exp_o[d]) begin
          n_fail++;
          $display("FAIL start_while_busy dut%0d t=%0d got=%b want=%b", d, t, obs[d], exp_o[d]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 50; t++) begin
      start = (t == 0) || (t == 9); dir = (t == 9); wheel_count = 5'd2;
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if (obs[d] !== exp_o[d]) begin
          n_fail++;
          $display("FAIL back_to_back dut%0d t=%0d got=%b want=%b", d, t, obs[d], exp_o[d]);
        end
      end
      if (t == 9) begin
        n_checks++;
        if (busy0 !== 1'b1 || ws0 !== 5'd0) begin
          n_fail++;
          $display("FAIL start_on_done busy=%b ws=%0d want 1 0", busy0, ws0);
        end
      end
    end
  endtask

`ifdef WHEEL_EMU_QUEUE_EN
  task automatic test_queue();
    for (int t = 0; t < 45; t++) begin
      start = (t == 0) || (t == 3); dir = (t >= 3); wheel_count = 5'd2;
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if (obs[d] !== exp_o[d]) begin
          n_fail++;
          $display("FAIL queue dut%0d t=%0d got=%b want=%b", d, t, obs[d], exp_o[d]);
        end
      end
      if (t == 8 || t == 16) begin
        n_checks++;
        if (done0 !== 1'b1 || busy0 !== (t == 8)) begin
          n_fail++;
          $display("FAIL queue_done t=%0d done=%b busy=%b", t, done0, busy0);
        end
      end
    end
  endtask
`endif

  task automatic test_reset_mid();
    for (int t = 0; t < 8; t++) begin
      start = (t == 0); dir = 1'b1; wheel_count = 5'd4;
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if (obs[d] !== exp_o[d]) begin
          n_fail++;
          $display("FAIL pre_reset dut%0d t=%0d got=%b want=%b", d, t, obs[d], exp_o[d]);
        end
      end
    end
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (obs[d] !== 9'd0) begin
        n_fail++;
        $display("FAIL async_reset dut%0d got=%b want=%b", d, obs[d], 9'd0);
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int t = 0; t < 14; t++) begin
      start = (t == 0); dir = 1'b0; wheel_count = 5'd1;
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if (obs[d] !== exp_o[d]) begin
          n_fail++;
          $display("FAIL post_reset dut%0d t=%0d got=%b want=%b", d, t, obs[d], exp_o[d]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic rd;
    int   n, ab_t, inj_t;
    for (int r = 0; r < 6; r++) begin
      rd    = 1'($urandom);
      n     = $urandom_range(1, 16);
      ab_t  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 140) : -1;
      inj_t = $urandom_range(1, 120);
      for (int t = 0; t < 300; t++) begin
        start       = (t == 0) || (t == inj_t);
        dir         = (t == 0) ? rd : 1'($urandom);
        wheel_count = (t == 0) ? 5'(n) : 5'($urandom_range(0, 16));
        abort       = (t == ab_t);
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) begin
          n_checks++;
          if (obs[d] !== exp_o[d]) begin
            n_fail++;
            $display("FAIL random r=%0d dut%0d t=%0d got=%b want=%b", r, d, t, obs[d], exp_o[d]);
          end
        end
      end
    end
    start = 1'b0; abort = 1'b0;
  endtask

  initial begin
    test_reset();
    test_forward();
    test_reverse();
    test_abort();
    test_ignored();
    test_back_to_back();
`ifdef WHEEL_EMU_QUEUE_EN
    test_queue();
`endif
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wheel_sensor_emulator.md
# wheel_sensor_emulator

Synthesizable train-passage generator for the level-crossing design. It drives the two-sensor wheel signals (a, b) of one track with the exact waveform a real axle produces: 00 → lead → 11 → trail per wheel, for a commanded direction and wheel count. It is the transmit-side counterpart of the wheel-direction decoder and counter in the crossing controller. Its outputs connect directly to the controller's a1/b1 or a2/b2 inputs for on-board self-test and hardware-in-the-loop runs.

## Interface
- PHASE_CYCLES, 1: clock cycles each sensor phase is held; legal range 1..255.
- COUNT_W, 4: wheel-counter width; a train carries 1..2^COUNT_W wheels.
- Clk  in  1  rising-edge clock
- Reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle train request; sampled only when idle
- dir  in  1  0 = a→b (a leads), 1 = b→a (b leads); latched on accepted start
- wheel_count  in  COUNT_W+1  wheels in the train; latched on accepted start; 0 = request ignored
- abort  in  1  stop the train immediately
- a  out  1  sensor A, registered
- b  out  1  sensor B, registered
- busy  out  1  high while a train is being emitted
- done  out  1  one-cycle pulse when the last wheel completes
- wheels_sent  out  COUNT_W+1  wheels completed in the current or last train

## Operation
- States: IDLE, GAP (a=b=0), LEAD (lead sensor only), BOTH (a=b=1), TRAIL (trail sensor only).
- Lead sensor is a when dir=0 and b when dir=1. Trail sensor is the other one.
- IDLE + start + wheel_count≠0 → GAP. On this transition: busy=1, wheels_sent=0, dir and count latched.
- Each of GAP, LEAD and BOTH lasts PHASE_CYCLES cycles, then advances to the next state in order.
- When TRAIL expires: wheels_sent increments. If wheels_sent now equals the latched count, go to IDLE with a=b=0, busy=0 and done=1 for one cycle. Otherwise go to GAP.
- start with wheel_count=0, or start while busy, is ignored (but see Configuration).
- abort has priority over everything. On the next edge: IDLE, a=b=0, busy=0, no done; wheels_sent holds the partial count.
- start and abort in the same idle cycle: abort wins and the request is dropped.
- Changes to dir and wheel_count during a train have no effect.

## Timing
- Reset values: a=0, b=0, busy=0, done=0, wheels_sent=0, state IDLE. Reset_n asserted mid-train forces all of these immediately.
- Start accepted at edge k: busy=1 and a=b=0 from edge k.
- For wheel i (0-based, P = PHASE_CYCLES): lead rises at k+(4i+1)P, both at k+(4i+2)P, trail-only at k+(4i+3)P.
- Train of N wheels: at edge k+4NP, busy falls, done pulses, a=b=0. Total length is 4NP cycles.
- Only one of a/b changes per transition (Gray sequence); no glitches.
- A new start is accepted in the same cycle done is high, because the block is already IDLE.

## Configuration
- WHEEL_EMU_QUEUE_EN defined: a start (wheel_count≠0) arriving while busy is captured in a one-deep queue holding dir and count. Further starts while the queue is full are ignored.
  - At train end, done pulses and the queued train begins on the same edge: busy stays 1 and state goes to GAP. This models the reversal corner case: back-to-back opposite-direction trains with no idle gap.
  - abort also clears the queue.
- WHEEL_EMU_QUEUE_EN undefined: a start while busy is ignored; no queue hardware.

## Structure
- wheel_emu_pkg: state enum; DIR_A2B=1'b0 and DIR_B2A=1'b1; the phase-counter width constant (8 bits).
- Sub-module wheel_phase_timer: loadable down-counter. Loads P-1 on state entry and asserts expire when it reaches zero. Instantiated once.

## Test plan
- Forward train, P=1: dir=0, count=16 → (a,b) = 00,10,11,01 repeated 16 times; busy high 64 cycles; done at edge k+64; wheels_sent=16.
- Reverse train, P=2: dir=1, count=3 → 00,01,11,10 with each phase held 2 cycles; done at k+24; wheels_sent=3.
- Abort: dir=0, count=8, abort at k+10 → next edge a=b=0, busy=0, no done; wheels_sent=2.
- Ignored requests: start with wheel_count=0 → busy stays 0. start at k+5 during a 4-wheel train (queue disabled) → done at k+16, then idle.
- Queue enabled: train dir=0 count=2, then start dir=1 count=2 at k+3 → done at k+8 and busy stays high; reversed pattern runs; second done at k+16.
- Reset mid-train: Reset_n low at k+7 → a, b, busy and wheels_sent go to 0 asynchronously; a start after release runs normally.
